// File: rtl/bf16_mult_pkg.sv
// Shared definitions for the BF16 multiplier arbiter: the arbiter FSM states
// and the BF16 operand width.
package bf16_mult_pkg;

  localparam int BF16_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr, wrapping
// around, and returns a one-hot grant for the first active request (or zero).
module rr_arbiter
  import bf16_mult_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  // First request at or after ptr (modulo N) wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bf16_mult_arbiter.sv
// Shares one external bf16_multiplier among NUM_REQ requesters. Each requester
// may have one op in flight; results land in per-requester slots and are held
// until consumed. halt_req stops issue and drains the multiplier pipe.
// Optional build macro MULT_ARB_STATS_EN adds the busy_cycles issue counter.
module bf16_mult_arbiter
  import bf16_mult_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_TYPE = BF16_W,
  parameter int MULT_LAT  = 1
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   req_A,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   req_B,
  output logic [DATA_TYPE-1:0]           mult_A,
  output logic [DATA_TYPE-1:0]           mult_B,
  input  logic [DATA_TYPE-1:0]           mult_O,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [NUM_REQ*DATA_TYPE-1:0]   rsp_O,
  input  logic                           halt_req,
  output logic                           halted
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]                    busy_cycles
`endif
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                     state_q, state_d;
  logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]             pending_q, pending_d;
  logic [MULT_LAT:0]              tag_vld_q, tag_vld_d;
  logic [MULT_LAT:0][ID_W-1:0]    tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_TYPE-1:0]   rsp_o_q, rsp_o_d;
  logic [DATA_TYPE-1:0]           mult_a_q, mult_a_d;
  logic [DATA_TYPE-1:0]           mult_b_q, mult_b_d;

  logic [NUM_REQ-1:0]             eligible;
  logic [NUM_REQ-1:0]             arb_grant;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             rsp_hs;
  logic                           issue;
  logic [ID_W-1:0]                gnt_id;
  logic                           pipe_empty;
  logic                           cap_vld;
  logic [ID_W-1:0]                cap_id;

  // A requester with an op still outstanding is never considered again.
  assign eligible = req_valid & ~pending_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (arb_grant)
  );

  // Grants only leave the block in RUN; encode the winner's index.
  always_comb begin
    grant  = (state_q == RUN) ? arb_grant : '0;
    issue  = |grant;
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_id = ID_W'(i);
    end
  end

  assign req_ready  = grant;
  assign pipe_empty = ~|tag_vld_q;
  assign cap_vld    = tag_vld_q[MULT_LAT];
  assign cap_id     = tag_id_q[MULT_LAT];
  assign rsp_hs     = rsp_valid_q & rsp_ready;

  // Halt sequencing: stop issuing, wait for the tag pipe to empty, then park.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req)       state_d = RUN;
        else if (pipe_empty) state_d = HALT;
      end
      HALT:    if (!halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Issue path, tag pipe, pending bookkeeping and result slots.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    mult_a_d = '0;
    mult_b_d = '0;
    if (issue) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      mult_a_d = req_A[gnt_id*DATA_TYPE +: DATA_TYPE];
      mult_b_d = req_B[gnt_id*DATA_TYPE +: DATA_TYPE];
    end

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = gnt_id;
    for (int k = 1; k <= MULT_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end

    pending_d   = (pending_q | grant) & ~rsp_hs;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_o_d     = rsp_o_q;
    if (cap_vld) begin
      rsp_valid_d[cap_id]                      = 1'b1;
      rsp_o_d[cap_id*DATA_TYPE +: DATA_TYPE]   = mult_O;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      pending_q   <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_o_q     <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_o_q     <= rsp_o_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
    end
  end

  assign mult_A    = mult_a_q;
  assign mult_B    = mult_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_O     = rsp_o_q;
  assign halted    = (state_q == HALT);

`ifdef MULT_ARB_STATS_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;

  // Saturating count of cycles in which an op was issued.
  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (issue && (busy_cycles_q != 32'hFFFF_FFFF)) busy_cycles_d = busy_cycles_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) busy_cycles_q <= '0;
    else     busy_cycles_q <= busy_cycles_d;
  end

  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: doc/bf16_mult_arbiter.md
BF16_MULT_ARBITER -- requirements
Module: bf16_mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one bf16_multiplier.
REQ-002 SHALL have parameter DATA_TYPE, default 16: operand/result width (BF16).
REQ-003 SHALL have parameter MULT_LAT, default 1: cycles from mult_A/mult_B to the matching mult_O (0 = combinational).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and rst.
REQ-005 CLK  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 req_A, req_B  input  NUM_REQ*DATA_TYPE  packed operands; slice i belongs to requester i.
REQ-010 mult_A, mult_B  output  DATA_TYPE  operands to the external bf16_multiplier.
REQ-011 mult_O  input  DATA_TYPE  multiplier product.
REQ-012 rsp_valid  output  NUM_REQ  result available for requester i.
REQ-013 rsp_ready  input  NUM_REQ  requester i consumes result.
REQ-014 rsp_O  output  NUM_REQ*DATA_TYPE  per-requester result slots.
REQ-015 halt_req  input  1  stop issuing and drain.
REQ-016 halted  output  1  no issue and pipeline empty while halt held.

Function
REQ-017 Each requester SHALL have a pending bit: set on req handshake, cleared on rsp handshake; max one outstanding op per requester.
REQ-018 Eligible(i) SHALL be req_valid[i] & ~pending[i]; the grant SHALL be round-robin, starting search at rr_ptr, with one grant per cycle.
REQ-019 req_ready[i] SHALL be combinational, high only for the granted i, and only in state RUN.
REQ-020 On grant, rr_ptr SHALL advance to (granted+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-021 Grant in cycle t SHALL register req_A[i]/req_B[i] onto mult_A/mult_B for cycle t+1; in non-issue cycles, mult_A/mult_B SHALL be 0.
REQ-022 The block SHALL carry a tag shift pipe (valid + log2(NUM_REQ) id) of depth MULT_LAT+1; mult_O SHALL be captured into slot id at the end of cycle t+1+MULT_LAT.
REQ-023 rsp_valid[i] SHALL rise in cycle t+2+MULT_LAT (latency 3 at default) and hold, with rsp_O stable, until the rsp_ready[i] handshake.
REQ-024 Capture and rsp handshake on the same slot in one cycle cannot occur (guaranteed by pending); req and rsp handshakes for the same i in one cycle SHALL leave pending cleared (no new grant that cycle, since pending was set).
REQ-025 FSM states SHALL be RUN, DRAIN and HALT.
REQ-026 RUN->DRAIN SHALL occur on halt_req; DRAIN SHALL make no grants, and DRAIN->HALT SHALL occur when the tag pipe is empty.
REQ-027 In HALT, halted SHALL be 1; HALT->RUN SHALL occur when halt_req drops; DRAIN->RUN SHALL occur if halt_req drops before empty.
REQ-028 Results still in slots SHALL remain deliverable in DRAIN and HALT.
REQ-029 rsp_O SHALL return the bits of mult_O unmodified; no rounding or flagging.

Reset
REQ-030 While rst=1, the block SHALL force: state=RUN, rr_ptr=0, pending=0, tag pipe empty, rsp_valid=0, rsp_O=0, mult_A=mult_B=0, halted=0.
REQ-031 Reset mid-operation SHALL discard in-flight ops without producing a response after release.

Configuration
REQ-032 With MULT_ARB_STATS_EN defined, the block SHALL add output busy_cycles (32-bit), incremented in every issue cycle, saturating at 0xFFFFFFFF, and reset to 0.
REQ-033 Without MULT_ARB_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-034 Package bf16_mult_pkg SHALL hold the FSM state enum (RUN/DRAIN/HALT) and the BF16 width constant.
REQ-035 The round-robin grant SHALL be sub-module rr_arbiter (req, ptr -> one-hot grant); bf16_multiplier SHALL stay external.

Verification
REQ-036 Single op: requester 0, A=0x4040, B=0x3F80 -> rsp_valid[0] 3 cycles after grant, rsp_O[0]=0x4040.
REQ-037 All 4 requesters valid at once (1.25x2.5, 8x1240, 1024x8192, 3x1) -> grants in cycles 0,1,2,3 in order 0,1,2,3; results 0x4048, 0x461B, 0x4B00, 0x4040 to the correct slots.
REQ-038 Requester 1 holds rsp_ready=0 while re-asserting req_valid -> no second grant to 1; other requesters keep being served; rr fairness preserved.
REQ-039 halt_req during back-to-back issue -> no grants after the halt cycle, halted=1 once the pipe empties (MULT_LAT+1 cycles), slots still drain; drop halt_req -> RUN.
REQ-040 rst pulse with 2 ops in flight -> all outputs at reset values, no rsp_valid afterwards; with MULT_ARB_STATS_EN, busy_cycles=0.
